dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Front-end controller for the word-only single-port Data_Memory. It shares the memory
//  between the core LSU (port C) and a debug/loader port (port D).
//  - Sub-word loads (LB/LH/LBU/LHU): lane extraction in the same cycle.
//  - Sub-word stores (SB/SH): two-cycle read-modify-write, core stalled meanwhile.
//  - Misaligned accesses: flagged, never reach the memory.
//  Sits between the core datapath/debug module and Data_Memory.
// PARAMETERS
//  DBG_MAX_WAIT  8   consecutive denied d_req cycles before D is forced a grant (>=1)
//  AW            32  address width
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  c_req       in   1   core access request
//  c_we        in   1   1=store, 0=load
//  c_size      in   2   00 byte, 01 half, 10 word (11 treated as word)
//  c_unsigned  in   1   zero-extend loads (LBU/LHU)
//  c_addr      in   AW  byte address
//  c_wdata     in   32  store data, right-justified
//  c_ready     out  1   access completes this cycle; low = core stall
//  c_rdata     out  32  extended load data, valid when c_ready & ~c_we
//  c_misalign  out  1   access misaligned, completed with no memory effect
//  d_req       in   1   debug request, word-only
//  d_we        in   1   debug store
//  d_addr      in   AW  debug byte address; [1:0] ignored (forced aligned)
//  d_wdata     in   32  debug store data
//  d_ready     out  1   debug access completes this cycle
//  d_rdata     out  32  debug load data
//  mem_addr    out  AW  to Data_Memory addr
//  mem_dataW   out  32  to Data_Memory dataW
//  mem_MemRW   out  1   to Data_Memory MemRW (1=write at posedge)
//  mem_dataR   in   32  from Data_Memory dataR (combinational read)
// BEHAVIOUR
//  Reset values: state=IDLE, wait_cnt=0, merge/addr regs=0.
//   Outputs: mem_MemRW=0, c_ready=0, d_ready=0, c_misalign=0, c_rdata/d_rdata=0.
//  FSM states: IDLE, RMW_WR.
//  IDLE, C wins (c_req & ~force_d):
//   - Misaligned (half with addr[0]=1, word with addr[1:0]!=0):
//     c_ready=1, c_misalign=1, c_rdata=0, mem_MemRW=0.
//   - Load: mem_addr={c_addr[AW-1:2],2'b00}, MemRW=0, c_ready=1 in the same cycle.
//     Byte/half taken from lane c_addr[1:0] (half: lane [1]), then sign/zero-extended.
//   - Word store: MemRW=1, dataW=c_wdata, c_ready=1 (write commits at this posedge).
//   - Byte/half store: MemRW=0 (read old word), c_ready=0.
//     Merged word (old word with the addressed lane replaced) and the aligned address
//     are registered; next state = RMW_WR.
//  RMW_WR:
//   - mem_addr=reg addr, dataW=reg merged, MemRW=1, c_ready=1, next state = IDLE.
//   - Live c_* inputs are ignored (core holds them stalled); D is never granted.
//  D grant: only in IDLE, when ~c_req or force_d.
//   - Load or store is single-cycle; d_ready=1 in that cycle.
//  Starvation guard: wait_cnt increments each cycle with d_req=1 and d_ready=0.
//   - Cleared on a D grant or when d_req=0; saturates at DBG_MAX_WAIT.
//   - force_d = (wait_cnt==DBG_MAX_WAIT). While force_d, C sees c_ready=0.
//  Idle cycle (no grant): MemRW=0, mem_addr=0.
//  MemRW is high only in a cycle that commits a grant, so a stall never double-writes.
//  Address range is not checked here; out-of-range behaviour belongs to Data_Memory.
//  Reset asserted in RMW_WR: the write is dropped, memory is unchanged, state=IDLE.
//  c_req withdrawn while in RMW_WR: the write still completes (the store is already
//  committed).
// STRUCTURE
//  Package dmem_pkg: size encodings MEM_B/MEM_H/MEM_W, state enum {IDLE,RMW_WR},
//   function is_misaligned(size, addr[1:0]).
//  Sub-module dmem_lane_align (combinational): store merge (old, wdata, size, lane)
//   and load extract (word, size, lane, unsigned).
//  Top level: FSM, arbiter and wait counter.
// TESTING
//  1 Word SW 0x0 <= DEADBEEF, then LW 0x0: c_ready=1 both cycles, c_rdata=DEADBEEF.
//  2 With mem[0]=11223344: SB 0x1 <= 0xAB gives 2 cycles, c_ready 0 then 1.
//    Writes 1122AB44; LB 0x1 -> FFFFFFAB; LBU 0x1 -> 000000AB.
//  3 SH 0x2 <= 0x8001 on mem[0]=11223344 -> 80013344; LH 0x2 -> FFFF8001.
//    LHU 0x2 -> 00008001.
//  4 LW 0x2, SH 0x3: c_misalign=1, c_ready=1 same cycle, c_rdata=0.
//    mem_MemRW stays 0; mem[0] unchanged.
//  5 c_req held high with loads, d_req=1 LW 0x10:
//    d_ready=1 on exactly the 9th cycle (DBG_MAX_WAIT=8), c_ready=0 in that cycle.
//  6 d_req SW 0x20 asserted during RMW_WR of SB 0x4: D is granted the cycle after RMW_WR.
//    Both writes land.
//    rst_n pulsed low during RMW_WR: mem word unchanged, all outputs 0.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller:
// access size encodings, FSM state type and the alignment rule.
package dmem_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

  // Size 2'b11 behaves exactly like a word access everywhere in the controller.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? MEM_W : size;
  endfunction

  // A half must sit on an even byte, a word on a multiple of four; bytes never misalign.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (norm_size(size))
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = lane[0];
      default: mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Bundle of the core (c_*), debug (d_*) and Data_Memory (mem_*) signals.
// The controller uses the slave view; the surrounding system uses master.
interface dmem_access_ctrl_if #(
  parameter int AW = 32
);

  logic          c_req;
  logic          c_we;
  logic [1:0]    c_size;
  logic          c_unsigned;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wdata;
  logic          c_ready;
  logic [31:0]   c_rdata;
  logic          c_misalign;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ready;
  logic [31:0]   d_rdata;

  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_dataW;
  logic          mem_MemRW;
  logic [31:0]   mem_dataR;

  modport slave (
    input  c_req, c_we, c_size, c_unsigned, c_addr, c_wdata,
    output c_ready, c_rdata, c_misalign,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ready, d_rdata,
    output mem_addr, mem_dataW, mem_MemRW,
    input  mem_dataR
  );

  modport master (
    output c_req, c_we, c_size, c_unsigned, c_addr, c_wdata,
    input  c_ready, c_rdata, c_misalign,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ready, d_rdata,
    input  mem_addr, mem_dataW, mem_MemRW,
    output mem_dataR
  );

endinterface

// File: rtl/dmem_access_ctrl_lane_align.sv
// Byte-lane steering between the 32-bit memory word and sub-word accesses:
// merges store data into an old word, and extracts/extends load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [1:0]  size_n;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign size_n   = norm_size(size);
  assign sel_byte = old_word[{lane, 3'b000} +: 8];
  assign sel_half = old_word[{lane[1], 4'b0000} +: 16];

  // Replace only the addressed lane of the old word with right-justified store data.
  always_comb begin
    merged = wdata;
    case (size_n)
      MEM_B: begin
        merged = old_word;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      MEM_H: begin
        merged = old_word;
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

  // Pull the addressed lane down to bit 0 and sign- or zero-extend it.
  always_comb begin
    extracted = old_word;
    case (size_n)
      MEM_B:   extracted = is_unsigned ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      MEM_H:   extracted = is_unsigned ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: extracted = old_word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Front end for the word-only single-port Data_Memory. Shares it between the
// core LSU and a debug/loader port, does sub-word loads in one cycle and
// sub-word stores as a two-cycle read-modify-write, and rejects misaligned
// core accesses before they reach memory.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DBG_MAX_WAIT = 8,
  parameter int AW           = 32
) (
  input logic              clk,
  input logic              rst_n,
  dmem_access_ctrl_if.slave bus
);

  localparam int            CW      = $clog2(DBG_MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(DBG_MAX_WAIT);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [AW-1:0] rmw_addr;
  logic [31:0]   rmw_data;

  logic          force_d;
  logic          c_grant;
  logic          d_grant;
  logic          c_mis;
  logic          c_sub_store;
  logic [1:0]    c_size_n;
  logic [AW-1:0] c_word_addr;
  logic [AW-1:0] d_word_addr;
  logic [31:0]   merged;
  logic [31:0]   extracted;

  assign c_size_n    = norm_size(bus.c_size);
  assign c_word_addr = {bus.c_addr[AW-1:2], 2'b00};
  assign d_word_addr = {bus.d_addr[AW-1:2], 2'b00};
  assign c_mis       = is_misaligned(c_size_n, bus.c_addr[1:0]);

  // The core owns the memory by default; the debug port only wins when the core
  // is quiet or the debug side has been starved long enough to force a grant.
  assign force_d     = (wait_cnt == MAX_CNT);
  assign c_grant     = (state == IDLE) && bus.c_req && !force_d;
  assign d_grant     = (state == IDLE) && bus.d_req && (!bus.c_req || force_d);
  assign c_sub_store = c_grant && !c_mis && bus.c_we && (c_size_n != MEM_W);

  dmem_lane_align u_align (
    .old_word    (bus.mem_dataR),
    .wdata       (bus.c_wdata),
    .size        (c_size_n),
    .lane        (bus.c_addr[1:0]),
    .is_unsigned (bus.c_unsigned),
    .merged      (merged),
    .extracted   (extracted)
  );

  // FSM: a sub-word store latches the merged word and its address, then writes it next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rmw_addr <= '0;
      rmw_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (c_sub_store) begin
            rmw_addr <= c_word_addr;
            rmw_data <= merged;
            state    <= RMW_WR;
          end
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation counter: counts denied debug cycles, saturating at the force threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!bus.d_req || d_grant) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Memory and handshake drive for the current cycle; everything is held at zero in
  // reset so an interrupted read-modify-write can never reach the memory.
  always_comb begin
    bus.mem_addr   = '0;
    bus.mem_dataW  = '0;
    bus.mem_MemRW  = 1'b0;
    bus.c_ready    = 1'b0;
    bus.c_rdata    = '0;
    bus.c_misalign = 1'b0;
    bus.d_ready    = 1'b0;
    bus.d_rdata    = '0;
    if (rst_n) begin
      if (state == RMW_WR) begin
        bus.mem_addr  = rmw_addr;
        bus.mem_dataW = rmw_data;
        bus.mem_MemRW = 1'b1;
        bus.c_ready   = 1'b1;
      end else if (c_grant) begin
        if (c_mis) begin
          bus.c_ready    = 1'b1;
          bus.c_misalign = 1'b1;
        end else if (!bus.c_we) begin
          bus.mem_addr = c_word_addr;
          bus.c_ready  = 1'b1;
          bus.c_rdata  = extracted;
        end else if (c_size_n == MEM_W) begin
          bus.mem_addr  = c_word_addr;
          bus.mem_dataW = bus.c_wdata;
          bus.mem_MemRW = 1'b1;
          bus.c_ready   = 1'b1;
        end else begin
          bus.mem_addr = c_word_addr;
        end
      end else if (d_grant) begin
        bus.mem_addr  = d_word_addr;
        bus.mem_dataW = bus.d_wdata;
        bus.mem_MemRW = bus.d_we;
        bus.d_ready   = 1'b1;
        bus.d_rdata   = bus.d_we ? 32'h0 : bus.mem_dataR;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a small behavioural Data_Memory.
module tb_dmem_access_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dmem_access_ctrl_if #(.AW(32)) bus ();

  dmem_access_ctrl #(.DBG_MAX_WAIT(8), .AW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural Data_Memory: combinational read, write at the rising edge.
  logic [31:0] mem [0:63];
  assign bus.mem_dataR = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus.mem_MemRW) mem[bus.mem_addr[7:2]] <= bus.mem_dataW;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the falling edge and let them settle.
  task automatic applyStimulus(input logic cr, input logic cw, input logic [1:0] cs,
                               input logic cu, input logic [31:0] ca, input logic [31:0] cwd,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dwd);
    @(negedge clk);
    bus.c_req      = cr;
    bus.c_we       = cw;
    bus.c_size     = cs;
    bus.c_unsigned = cu;
    bus.c_addr     = ca;
    bus.c_wdata    = cwd;
    bus.d_req      = dr;
    bus.d_we       = dw;
    bus.d_addr     = da;
    bus.d_wdata    = dwd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.c_req = 0; bus.c_we = 0; bus.c_size = 0; bus.c_unsigned = 0;
    bus.c_addr = 0; bus.c_wdata = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;

    // Reset state
    applyStimulus(1, 0, 2'b10, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0);
    checkOutput("rst_c_ready", 32'(bus.c_ready), 32'h0);
    checkOutput("rst_d_ready", 32'(bus.d_ready), 32'h0);
    checkOutput("rst_memrw", 32'(bus.mem_MemRW), 32'h0);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    rst_n = 1'b1;

    // 1: word store then word load
    applyStimulus(1, 1, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
    checkOutput("sw_ready", 32'(bus.c_ready), 32'h1);
    checkOutput("sw_memrw", 32'(bus.mem_MemRW), 32'h1);
    checkOutput("sw_dataw", bus.mem_dataW, 32'hDEADBEEF);
    applyStimulus(1, 0, 2'b10, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("lw_ready", 32'(bus.c_ready), 32'h1);
    checkOutput("lw_rdata", bus.c_rdata, 32'hDEADBEEF);

    // 2: SB 0x1 as read-modify-write, then signed/unsigned byte loads
    applyStimulus(1, 1, 2'b10, 0, 32'h0, 32'h11223344, 0, 0, 32'h0, 32'h0);
    applyStimulus(1, 1, 2'b00, 0, 32'h1, 32'h000000AB, 0, 0, 32'h0, 32'h0);
    checkOutput("sb_rd_ready", 32'(bus.c_ready), 32'h0);
    checkOutput("sb_rd_memrw", 32'(bus.mem_MemRW), 32'h0);
    applyStimulus(1, 1, 2'b00, 0, 32'h1, 32'h000000AB, 0, 0, 32'h0, 32'h0);
    checkOutput("sb_wr_ready", 32'(bus.c_ready), 32'h1);
    checkOutput("sb_wr_memrw", 32'(bus.mem_MemRW), 32'h1);
    checkOutput("sb_wr_dataw", bus.mem_dataW, 32'h1122AB44);
    applyStimulus(1, 0, 2'b00, 0, 32'h1, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("lb_rdata", bus.c_rdata, 32'hFFFFFFAB);
    applyStimulus(1, 0, 2'b00, 1, 32'h1, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("lbu_rdata", bus.c_rdata, 32'h000000AB);

    // 3: SH 0x2 on the upper half, then LH / LHU
    applyStimulus(1, 1, 2'b10, 0, 32'h0, 32'h11223344, 0, 0, 32'h0, 32'h0);
    applyStimulus(1, 1, 2'b01, 0, 32'h2, 32'h00008001, 0, 0, 32'h0, 32'h0);
    checkOutput("sh_rd_ready", 32'(bus.c_ready), 32'h0);
    applyStimulus(1, 1, 2'b01, 0, 32'h2, 32'h00008001, 0, 0, 32'h0, 32'h0);
    checkOutput("sh_wr_dataw", bus.mem_dataW, 32'h80013344);
    applyStimulus(1, 0, 2'b01, 0, 32'h2, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("lh_rdata", bus.c_rdata, 32'hFFFF8001);
    applyStimulus(1, 0, 2'b01, 1, 32'h2, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("lhu_rdata", bus.c_rdata, 32'h00008001);

    // 4: misaligned word load and half store never touch memory
    applyStimulus(1, 0, 2'b10, 0, 32'h2, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("mis_lw_flag", 32'(bus.c_misalign), 32'h1);
    checkOutput("mis_lw_ready", 32'(bus.c_ready), 32'h1);
    checkOutput("mis_lw_rdata", bus.c_rdata, 32'h0);
    applyStimulus(1, 1, 2'b01, 0, 32'h3, 32'h0000FFFF, 0, 0, 32'h0, 32'h0);
    checkOutput("mis_sh_flag", 32'(bus.c_misalign), 32'h1);
    checkOutput("mis_sh_ready", 32'(bus.c_ready), 32'h1);
    checkOutput("mis_sh_memrw", 32'(bus.mem_MemRW), 32'h0);
    applyStimulus(1, 0, 2'b10, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("mis_mem_kept", bus.c_rdata, 32'h80013344);
    checkOutput("aligned_noflag", 32'(bus.c_misalign), 32'h0);

    // 5: debug preload while core idle, then starvation guard under constant core loads
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hCAFEF00D);
    checkOutput("d_sw_ready", 32'(bus.d_ready), 32'h1);
    checkOutput("d_sw_memrw", 32'(bus.mem_MemRW), 32'h1);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1, 0, 2'b10, 0, 32'h0, 32'h0, 1, 0, 32'h13, 32'h0);
      checkOutput($sformatf("starve_d_ready_%0d", i), 32'(bus.d_ready), 32'(i == 9));
      checkOutput($sformatf("starve_c_ready_%0d", i), 32'(bus.c_ready), 32'(i != 9));
    end
    checkOutput("forced_d_rdata", bus.d_rdata, 32'hCAFEF00D);

    // 6: debug request during RMW_WR waits one cycle, both writes land
    applyStimulus(1, 1, 2'b10, 0, 32'h4, 32'h55667788, 0, 0, 32'h0, 32'h0);
    applyStimulus(1, 1, 2'b00, 0, 32'h4, 32'h00000099, 0, 0, 32'h0, 32'h0);
    checkOutput("sb4_rd_ready", 32'(bus.c_ready), 32'h0);
    applyStimulus(1, 1, 2'b00, 0, 32'h4, 32'h00000099, 1, 1, 32'h20, 32'h12345678);
    checkOutput("sb4_wr_ready", 32'(bus.c_ready), 32'h1);
    checkOutput("sb4_wr_dataw", bus.mem_dataW, 32'h55667799);
    checkOutput("rmw_d_blocked", 32'(bus.d_ready), 32'h0);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h12345678);
    checkOutput("after_rmw_d_ready", 32'(bus.d_ready), 32'h1);
    checkOutput("after_rmw_d_addr", bus.mem_addr, 32'h20);
    applyStimulus(1, 0, 2'b10, 0, 32'h4, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("sb4_landed", bus.c_rdata, 32'h55667799);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 1, 0, 32'h23, 32'h0);
    checkOutput("d_sw_landed", bus.d_rdata, 32'h12345678);

    // Reset during RMW_WR drops the write
    applyStimulus(1, 1, 2'b00, 0, 32'h4, 32'h00000000, 0, 0, 32'h0, 32'h0);
    checkOutput("rst_rmw_rd_ready", 32'(bus.c_ready), 32'h0);
    applyStimulus(1, 1, 2'b00, 0, 32'h4, 32'h00000000, 0, 0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rmw_memrw", 32'(bus.mem_MemRW), 32'h0);
    checkOutput("rst_rmw_c_ready", 32'(bus.c_ready), 32'h0);
    checkOutput("rst_rmw_d_ready", 32'(bus.d_ready), 32'h0);
    checkOutput("rst_rmw_c_rdata", bus.c_rdata, 32'h0);
    checkOutput("rst_rmw_c_mis", 32'(bus.c_misalign), 32'h0);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1, 0, 2'b10, 0, 32'h4, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("rst_rmw_mem_kept", bus.c_rdata, 32'h55667799);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
